// File: rtl/lcd_fb_writer_pkg.sv
// ============================================================================
// lcd_fb_writer_pkg : shared LCD constants and FSM encoding (read and write side)
// Revision 1.0
// ============================================================================
`default_nettype none

package lcd_fb_writer_pkg;

  localparam int H_RES_DEF = 240;
  localparam int V_RES_DEF = 320;
  localparam int RGB565_W  = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } lcd_state_e;

endpackage

`default_nettype wire

// File: rtl/lcd_rect_cnt.sv
// ============================================================================
// lcd_rect_cnt : rectangle col/row walker with row-base accumulator.
// Optional LCD_FB_CLIP_EN flags pixels that fall outside the visible frame.
// Revision 1.0
// ============================================================================
`default_nettype none

module lcd_rect_cnt
  import lcd_fb_writer_pkg::*;
#(
  parameter int H_RES      = H_RES_DEF,
  parameter int V_RES      = V_RES_DEF,
  parameter int ADDR_WIDTH = 17
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  load_i,
  input  logic                  adv_i,
  input  logic [8:0]            x0_i,
  input  logic [8:0]            y0_i,
  input  logic [8:0]            w_i,
  input  logic [8:0]            h_i,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic                  last_o,
  output logic                  offscreen_o
);

  localparam logic [ADDR_WIDTH-1:0] c_hres = ADDR_WIDTH'(H_RES);
`ifdef LCD_FB_CLIP_EN
  localparam bit c_clip_en = 1'b1;
`else
  localparam bit c_clip_en = 1'b0;
`endif

  logic [8:0]            col_q, col_d, row_q, row_d;
  logic [8:0]            w_q, w_d, h_q, h_d;
  logic [8:0]            x0_q, x0_d, y0_q, y0_d;
  logic [ADDR_WIDTH-1:0] row_base_q, row_base_d;
  logic                  col_last;
  logic [9:0]            x_cur, y_cur;

  assign col_last = (col_q == w_q - 9'd1);
  assign last_o   = col_last && (row_q == h_q - 9'd1);
  assign addr_o   = row_base_q + ADDR_WIDTH'(col_q);

  // Coordinates are one bit wider so x0+col cannot wrap before the compare.
  assign x_cur       = {1'b0, x0_q} + {1'b0, col_q};
  assign y_cur       = {1'b0, y0_q} + {1'b0, row_q};
  assign offscreen_o = c_clip_en &&
                       ((32'(x_cur) >= 32'(H_RES)) || (32'(y_cur) >= 32'(V_RES)));

  always_comb begin
    col_d      = col_q;
    row_d      = row_q;
    w_d        = w_q;
    h_d        = h_q;
    x0_d       = x0_q;
    y0_d       = y0_q;
    row_base_d = row_base_q;
    if (load_i) begin
      col_d      = '0;
      row_d      = '0;
      w_d        = w_i;
      h_d        = h_i;
      x0_d       = x0_i;
      y0_d       = y0_i;
      row_base_d = ADDR_WIDTH'(y0_i) * c_hres + ADDR_WIDTH'(x0_i);
    end else if (adv_i) begin
      if (col_last) begin
        col_d      = '0;
        row_d      = row_q + 9'd1;
        row_base_d = row_base_q + c_hres;
      end else begin
        col_d = col_q + 9'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      col_q      <= '0;
      row_q      <= '0;
      w_q        <= '0;
      h_q        <= '0;
      x0_q       <= '0;
      y0_q       <= '0;
      row_base_q <= '0;
    end else begin
      col_q      <= col_d;
      row_q      <= row_d;
      w_q        <= w_d;
      h_q        <= h_d;
      x0_q       <= x0_d;
      y0_q       <= y0_d;
      row_base_q <= row_base_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/lcd_fb_writer.sv
// ============================================================================
// lcd_fb_writer : writes a valid/ready pixel stream into a rectangle of the
// LCD frame buffer. Define LCD_FB_CLIP_EN to suppress off-screen writes.
// Revision 1.0
// ============================================================================
`default_nettype none

module lcd_fb_writer
  import lcd_fb_writer_pkg::*;
#(
  parameter int H_RES      = H_RES_DEF,
  parameter int V_RES      = V_RES_DEF,
  parameter int ADDR_WIDTH = 17,
  parameter int DATA_WIDTH = RGB565_W
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start,
  input  logic [8:0]            x0,
  input  logic [8:0]            y0,
  input  logic [8:0]            w,
  input  logic [8:0]            h,
  input  logic                  pix_valid,
  input  logic [DATA_WIDTH-1:0] pix_data,
  output logic                  pix_ready,
  output logic                  busy,
  output logic                  done,
  output logic                  we,
  output logic [ADDR_WIDTH-1:0] waddr,
  output logic [DATA_WIDTH-1:0] wdata
);

  lcd_state_e            state_q;
  logic                  pix_ready_q, busy_q, done_q, we_q;
  logic [ADDR_WIDTH-1:0] waddr_q;
  logic [DATA_WIDTH-1:0] wdata_q;

  logic                  nonzero, load, xfer, last, offscreen;
  logic [ADDR_WIDTH-1:0] addr;

  assign nonzero = (w != 9'd0) && (h != 9'd0);
  assign load    = (state_q == ST_IDLE) && start && nonzero;
  // pix_ready_q is only ever high in RUN, so it doubles as the state qualifier.
  assign xfer    = pix_valid && pix_ready_q;

  lcd_rect_cnt #(
    .H_RES      (H_RES),
    .V_RES      (V_RES),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_cnt (
    .clk         (clk),
    .rstn        (rstn),
    .load_i      (load),
    .adv_i       (xfer),
    .x0_i        (x0),
    .y0_i        (y0),
    .w_i         (w),
    .h_i         (h),
    .addr_o      (addr),
    .last_o      (last),
    .offscreen_o (offscreen)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= ST_IDLE;
      pix_ready_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      we_q        <= 1'b0;
      waddr_q     <= '0;
      wdata_q     <= '0;
    end else begin
      we_q   <= 1'b0;
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            busy_q <= 1'b1;
            if (nonzero) begin
              state_q     <= ST_RUN;
              pix_ready_q <= 1'b1;
            end else begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (xfer) begin
            we_q    <= ~offscreen;
            waddr_q <= addr;
            wdata_q <= pix_data;
            if (last) begin
              state_q     <= ST_DONE;
              pix_ready_q <= 1'b0;
              done_q      <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q     <= ST_IDLE;
          pix_ready_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign pix_ready = pix_ready_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign we        = we_q;
  assign waddr     = waddr_q;
  assign wdata     = wdata_q;

endmodule

`default_nettype wire
